// File: rtl/vec_vsetvl_unit.sv
// vec_vsetvl_unit: executes vsetvli / vsetivli / vsetvl.
// Latches the instruction, computes the new vtype, VLMAX and vl, then issues
// a one-cycle CSR write and returns the new vl to the scalar core.
module vec_vsetvl_unit #(
  parameter int XLEN = 32,
  parameter int VLEN = 512
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            inst_valid,
  output logic            inst_ready,
  input  logic [XLEN-1:0] inst,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] cur_vl,
  input  logic            flush,
  output logic            csrwr_en,
  output logic [XLEN-1:0] scalar1,
  output logic [XLEN-1:0] scalar2,
  output logic            rd_wr_en,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] rd_data,
  output logic            done,
  output logic            illegal
);

  localparam logic [XLEN-1:0] VLEN_X = XLEN'(VLEN);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    WRITE
  } state_t;

  state_t state, state_nxt;

  logic [XLEN-1:0] inst_q, rs1_q, rs2_q, cur_vl_q;
  logic            ill_q;

  logic            is_vli, is_vili, is_vl, enc_ok, vtype_ok, calc_ill;
  logic [XLEN-1:0] vtype_raw, vlmax, avl, new_vl;
  logic [2:0]      sew_shift;
  logic [4:0]      rd_f, rs1_f;

  // State register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic and WRITE-cycle strobes
  always_comb begin
    state_nxt  = state;
    inst_ready = 1'b0;
    done       = 1'b0;
    csrwr_en   = 1'b0;
    illegal    = 1'b0;
    rd_wr_en   = 1'b0;
    unique case (state)
      IDLE: begin
        inst_ready = 1'b1;
        if (inst_valid) state_nxt = CALC;
      end
      CALC: begin
        state_nxt = flush ? IDLE : WRITE;
      end
      WRITE: begin
        done      = 1'b1;
        csrwr_en  = !ill_q;
        illegal   = ill_q;
        rd_wr_en  = (rd_addr != 5'd0);
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Decode, vtype legality, VLMAX and vl from the latched operands
  always_comb begin
    rd_f     = inst_q[11:7];
    rs1_f    = inst_q[19:15];
    is_vli   = (inst_q[31] == 1'b0);
    is_vili  = (inst_q[31:30] == 2'b11);
    is_vl    = (inst_q[31:25] == 7'b1000000);
    enc_ok   = (inst_q[6:0] == 7'h57) && (inst_q[14:12] == 3'b111)
               && (is_vli || is_vili || is_vl);
    vtype_raw = rs2_q;
    if (is_vli)       vtype_raw = XLEN'(inst_q[30:20]);
    else if (is_vili) vtype_raw = XLEN'(inst_q[29:20]);
    // vsew >= 4 is exactly bit 5 set; fractional/reserved vlmul is bit 2 set
    vtype_ok  = (vtype_raw[XLEN-1:8] == '0) && !vtype_raw[5] && !vtype_raw[2];
    sew_shift = 3'd3 + {1'b0, vtype_raw[4:3]};
    vlmax     = (VLEN_X >> sew_shift) << vtype_raw[1:0];
    if (is_vili)             avl = XLEN'(rs1_f);
    else if (rs1_f != 5'd0)  avl = rs1_q;
    else if (rd_f != 5'd0)   avl = vlmax;
    else                     avl = cur_vl_q;
    new_vl   = (avl < vlmax) ? avl : vlmax;
    calc_ill = !(enc_ok && vtype_ok);
  end

  // Operand capture at handshake and result registers loaded at the end of CALC
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inst_q   <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      cur_vl_q <= '0;
      ill_q    <= 1'b0;
      scalar1  <= '0;
      scalar2  <= '0;
      rd_addr  <= '0;
      rd_data  <= '0;
    end else begin
      if (state == IDLE && inst_valid) begin
        inst_q   <= inst;
        rs1_q    <= rs1_data;
        rs2_q    <= rs2_data;
        cur_vl_q <= cur_vl;
      end
      if (state == CALC && !flush) begin
        ill_q   <= calc_ill;
        rd_addr <= rd_f;
        rd_data <= calc_ill ? '0 : new_vl;
        if (!calc_ill) begin
          scalar1 <= new_vl;
          scalar2 <= XLEN'(vtype_raw[7:0]);
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_vsetvl_unit.sv
// Testbench for vec_vsetvl_unit: directed and randomized instructions checked
// against an arithmetic reference model.
module tb_vec_vsetvl_unit;

  localparam int XLEN = 32;
  localparam int VLEN = 512;

  logic            clk = 1'b0;
  logic            n_rst = 1'b0;
  logic            inst_valid = 1'b0;
  logic            inst_ready;
  logic [XLEN-1:0] inst = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic [XLEN-1:0] cur_vl = '0;
  logic            flush = 1'b0;
  logic            csrwr_en;
  logic [XLEN-1:0] scalar1;
  logic [XLEN-1:0] scalar2;
  logic            rd_wr_en;
  logic [4:0]      rd_addr;
  logic [XLEN-1:0] rd_data;
  logic            done;
  logic            illegal;

  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;

  vec_vsetvl_unit #(.XLEN(XLEN), .VLEN(VLEN)) dut (
    .clk(clk), .n_rst(n_rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .rs1_data(rs1_data), .rs2_data(rs2_data), .cur_vl(cur_vl),
    .flush(flush), .csrwr_en(csrwr_en), .scalar1(scalar1), .scalar2(scalar2),
    .rd_wr_en(rd_wr_en), .rd_addr(rd_addr), .rd_data(rd_data), .done(done),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          ill;
    int unsigned vl;
    int unsigned vtype;
    bit          rd_we;
    int unsigned rd;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_vli(input int unsigned vt, input int unsigned rs1, input int unsigned rd);
    logic [10:0] v = vt[10:0];
    logic [4:0]  a = rs1[4:0];
    logic [4:0]  d = rd[4:0];
    return {1'b0, v, a, 3'b111, d, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vili(input int unsigned vt, input int unsigned uimm, input int unsigned rd);
    logic [9:0] v = vt[9:0];
    logic [4:0] u = uimm[4:0];
    logic [4:0] d = rd[4:0];
    return {2'b11, v, u, 3'b111, d, 7'h57};
  endfunction

  function automatic logic [31:0] enc_vl(input int unsigned rs2, input int unsigned rs1, input int unsigned rd);
    logic [4:0] b = rs2[4:0];
    logic [4:0] a = rs1[4:0];
    logic [4:0] d = rd[4:0];
    return {7'b1000000, b, a, 3'b111, d, 7'h57};
  endfunction

  // Reference model: derives the expected result straight from the ISA rules.
  function automatic exp_t model(input logic [31:0] i, input int unsigned r1,
                                 input int unsigned r2, input int unsigned cv);
    exp_t e;
    int unsigned vt, vsew, vlmul, sew_bits, vlmax, avl, rs1i, rdi;
    bit known, is_imm;
    rdi    = int'(i[11:7]);
    rs1i   = int'(i[19:15]);
    known  = 1'b1;
    is_imm = 1'b0;
    vt     = 0;
    if (i[31] == 1'b0)               vt = int'(i[30:20]);
    else if (i[31:30] == 2'b11)      begin vt = int'(i[29:20]); is_imm = 1'b1; end
    else if (i[31:25] == 7'b1000000) vt = r2;
    else                             known = 1'b0;
    vsew  = (vt / 8) % 8;
    vlmul = vt % 8;
    e.ill = !(known && i[6:0] == 7'h57 && i[14:12] == 3'b111 && vt < 256 && vsew < 4 && vlmul < 4);
    sew_bits = 8 * (2 ** vsew);
    vlmax = (VLEN / sew_bits) * (2 ** vlmul);
    if (is_imm)         avl = rs1i;
    else if (rs1i != 0) avl = r1;
    else if (rdi != 0)  avl = vlmax;
    else                avl = cv;
    e.vl    = e.ill ? 0 : ((avl < vlmax) ? avl : vlmax);
    e.vtype = vt;
    e.rd    = rdi;
    e.rd_we = (rdi != 0);
    return e;
  endfunction

  // Issues one instruction and checks the whole transaction at T+1, T+2, T+3.
  task automatic issue(input logic [31:0] i, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [31:0] cv, input string tag);
    exp_t e;
    int unsigned guard = 0;
    while (!inst_ready && guard < 10) begin
      @(posedge clk); #1;
      guard++;
    end
    check({tag, "_ready_wait"}, 32'(inst_ready), 32'd1);
    e = model(i, r1, r2, cv);
    inst = i; rs1_data = r1; rs2_data = r2; cur_vl = cv; inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    inst = $urandom; rs1_data = $urandom; rs2_data = $urandom; cur_vl = $urandom;
    check({tag, "_busy"}, 32'(inst_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done"},     32'(done),     32'd1);
    check({tag, "_illegal"},  32'(illegal),  32'(e.ill));
    check({tag, "_csrwr"},    32'(csrwr_en), 32'(!e.ill));
    check({tag, "_rdwe"},     32'(rd_wr_en), 32'(e.rd_we));
    check({tag, "_rdaddr"},   32'(rd_addr),  e.rd);
    check({tag, "_rddata"},   rd_data,       e.vl);
    if (!e.ill) begin
      check({tag, "_scalar1"}, scalar1, e.vl);
      check({tag, "_scalar2"}, scalar2, e.vtype);
    end
    @(posedge clk); #1;
    check({tag, "_ready_after"}, 32'(inst_ready), 32'd1);
    check({tag, "_done_after"},  32'(done),       32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_ready",   32'(inst_ready), 32'd1);
    check("rst_strobes", {28'd0, csrwr_en, rd_wr_en, done, illegal}, 32'd0);
    check("rst_scalar1", scalar1, 32'd0);
    check("rst_scalar2", scalar2, 32'd0);
    check("rst_rd",      {rd_addr, rd_data[26:0]}, 32'd0);
    @(negedge clk); n_rst = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    issue(enc_vli(32'h11, 5, 6), 100, 0, 0, "vli_e32m2");
    issue(enc_vili(32'h00, 5, 1), 0, 0, 0, "vili_u5");
    issue(enc_vili(32'h18, 31, 1), 0, 0, 0, "vili_u31_e64");
    issue(enc_vli(32'h1B, 0, 7), 12345, 0, 0, "vli_x0_rd7");
    issue(enc_vli(32'h08, 0, 0), 0, 0, 20, "vli_x0x0_cv20");
    issue(enc_vli(32'h08, 0, 0), 0, 0, 50, "vli_x0x0_cv50");
    issue(enc_vl(2, 1, 3), 10, 32'h14, 0, "vl_lmul4");
    issue(enc_vl(2, 1, 3), 10, 32'h100, 0, "vl_bit8");
    issue(enc_vl(2, 1, 4), 32'hFFFF_FFFF, 32'h03, 0, "vl_big_avl");
    issue({17'd0, 3'b111, 5'd0, 7'h33}, 0, 0, 0, "bad_opcode");
    issue(enc_vli(32'h20, 1, 2), 9, 0, 0, "vli_sew128");

    // Flush during CALC: instruction abandoned without strobes
    inst = enc_vli(32'h11, 5, 6); rs1_data = 100; inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_done",  32'(done), 32'd0);
    check("flush_csrwr", 32'(csrwr_en), 32'd0);
    check("flush_ready", 32'(inst_ready), 32'd1);
    @(posedge clk); #1;
    check("flush_quiet", {30'd0, done, rd_wr_en}, 32'd0);

    // Flush in the handshake cycle is ignored
    inst = enc_vli(32'h10, 5, 6); rs1_data = 100; inst_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    check("hs_flush_done", 32'(done), 32'd1);
    check("hs_flush_vl",   scalar1, 32'd16);
    @(posedge clk); #1;

    // Reset asserted during WRITE
    inst = enc_vli(32'h11, 5, 6); rs1_data = 100; inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    @(posedge clk); #1;
    check("rstw_done_pre", 32'(done), 32'd1);
    n_rst = 1'b0;
    #1;
    check("rstw_strobes", {28'd0, csrwr_en, rd_wr_en, done, illegal}, 32'd0);
    check("rstw_ready",   32'(inst_ready), 32'd1);
    check("rstw_payload", scalar1 | scalar2 | rd_data | 32'(rd_addr), 32'd0);
    #2 n_rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("rstw_no_strobe", 32'(done), 32'd0);
    end

    // inst_valid held high across two instructions
    inst = enc_vli(32'h11, 5, 6); rs1_data = 100; inst_valid = 1'b1;
    @(posedge clk); #1;
    check("b2b_t1_busy", 32'(inst_ready), 32'd0);
    @(posedge clk); #1;
    check("b2b_t2_done", 32'(done), 32'd1);
    @(posedge clk); #1;
    check("b2b_t3_ready", 32'(inst_ready), 32'd1);
    check("b2b_t3_done",  32'(done), 32'd0);
    @(posedge clk); #1;
    check("b2b_t4_busy", 32'(inst_ready), 32'd0);
    check("b2b_t4_done", 32'(done), 32'd0);
    @(posedge clk); #1;
    check("b2b_t5_done", 32'(done), 32'd1);
    check("b2b_t5_vl",   scalar1, 32'd32);
    inst_valid = 1'b0;
    @(posedge clk); #1;

    // Randomized instructions
    for (int n = 0; n < 60; n++) begin
      logic [31:0] ri, r1, r2, cv;
      int unsigned kind, vt, a, d;
      kind = $urandom_range(0, 9);
      vt   = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 63);
      a    = $urandom_range(0, 3);
      d    = $urandom_range(0, 3);
      r1   = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 700) : $urandom;
      r2   = vt;
      cv   = $urandom_range(0, 600);
      if (kind < 4)      ri = enc_vli(vt, a, d);
      else if (kind < 6) ri = enc_vili(vt % 1024, $urandom_range(0, 31), d);
      else if (kind < 9) ri = enc_vl(2, a, d);
      else               ri = $urandom;
      issue(ri, r1, r2, cv, "rand");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
